// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus master: issues one word/byte read or write per
// command through IDLE -> ADDR -> STROBE -> TERM, with a Dtack timeout.
module m68k_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        Start,
  input  logic        CmdWrite,
  input  logic        CmdByte,
  input  logic [31:0] CmdAddr,
  input  logic [15:0] CmdData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] RdData,
  output logic [31:0] Address,
  output logic [15:0] DataOut,
  input  logic [15:0] DataIn,
  output logic        AS_L,
  output logic        UDS_L,
  output logic        LDS_L,
  output logic        WE_L,
  input  logic        Dtack_L
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    TERM   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_write;
  logic             r_byte;
  logic             r_a0;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [15:0]      w_wdata;
  logic [15:0]      w_rdata;
  logic             w_misaligned;
  logic             w_timeout;

  // Byte writes replicate the low byte so either lane carries it.
  assign w_wdata      = CmdByte ? {CmdData[7:0], CmdData[7:0]} : CmdData;
  assign w_misaligned = ~CmdByte & CmdAddr[0];
  assign w_timeout    = (17'(r_cnt) + 17'd1) >= 17'(TIMEOUT_CYCLES);
  assign w_rdata      = !r_byte ? DataIn :
                        (r_a0 ? {8'h00, DataIn[7:0]} : {8'h00, DataIn[15:8]});

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_a0    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
      RdData  <= '0;
      Address <= '0;
      DataOut <= '0;
      AS_L    <= 1'b1;
      UDS_L   <= 1'b1;
      LDS_L   <= 1'b1;
      WE_L    <= 1'b1;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            Busy    <= 1'b1;
            r_write <= CmdWrite;
            r_byte  <= CmdByte;
            r_a0    <= CmdAddr[0];
            // A misaligned word never touches the bus; report it from TERM.
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= TERM;
            end else begin
              r_err   <= 1'b0;
              Address <= CmdAddr;
              DataOut <= w_wdata;
              WE_L    <= ~CmdWrite;
              r_state <= ADDR;
            end
          end
        end
        ADDR: begin
          AS_L    <= 1'b0;
          UDS_L   <= r_byte & r_a0;
          LDS_L   <= r_byte & ~r_a0;
          r_cnt   <= '0;
          r_state <= STROBE;
        end
        STROBE: begin
          if (!Dtack_L) begin
            if (!r_write) RdData <= w_rdata;
            AS_L    <= 1'b1;
            UDS_L   <= 1'b1;
            LDS_L   <= 1'b1;
            WE_L    <= 1'b1;
            r_state <= TERM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout) begin
              r_err   <= 1'b1;
              AS_L    <= 1'b1;
              UDS_L   <= 1'b1;
              LDS_L   <= 1'b1;
              WE_L    <= 1'b1;
              r_state <= TERM;
            end
          end
        end
        TERM: begin
          // Wait for the responder to release Dtack before finishing.
          if (Dtack_L) begin
            Done    <= 1'b1;
            Error   <= r_err;
            Busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed-vector bench for m68k_bus_master with a simple synchronous
// Dtack responder (configurable assert delay and release hold).
module tb_m68k_bus_master;

  logic        Clock    = 1'b0;
  logic        Reset_H  = 1'b1;
  logic        Start    = 1'b0;
  logic        CmdWrite = 1'b0;
  logic        CmdByte  = 1'b0;
  logic [31:0] CmdAddr  = '0;
  logic [15:0] CmdData  = '0;
  logic [15:0] DataIn   = '0;
  logic        Dtack_L  = 1'b1;
  logic        Busy, Done, Error;
  logic [15:0] RdData, DataOut;
  logic [31:0] Address;
  logic        AS_L, UDS_L, LDS_L, WE_L;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_delay = 0;
  int resp_hold  = 0;
  int low_cnt    = 0;
  int hold_cnt   = 0;

  typedef struct {
    logic        wr;
    logic        byt;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          dly;
    int          hold;
    int          lat;
    int          asn;
    logic        uds;
    logic        lds;
    logic        err;
    logic [15:0] rd;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [11];

  m68k_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .Clock    (Clock),
    .Reset_H  (Reset_H),
    .Start    (Start),
    .CmdWrite (CmdWrite),
    .CmdByte  (CmdByte),
    .CmdAddr  (CmdAddr),
    .CmdData  (CmdData),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .RdData   (RdData),
    .Address  (Address),
    .DataOut  (DataOut),
    .DataIn   (DataIn),
    .AS_L     (AS_L),
    .UDS_L    (UDS_L),
    .LDS_L    (LDS_L),
    .WE_L     (WE_L),
    .Dtack_L  (Dtack_L)
  );

  always #5 Clock = ~Clock;

  // Responder: assert Dtack resp_delay clocks after AS_L falls, release it
  // resp_hold clocks after AS_L rises.
  always @(posedge Clock) begin
    #1;
    if (AS_L == 1'b0) begin
      hold_cnt = 0;
      if (low_cnt >= resp_delay) Dtack_L = 1'b0;
      low_cnt++;
    end else begin
      low_cnt = 0;
      if (Dtack_L == 1'b0) begin
        if (hold_cnt >= resp_hold) Dtack_L = 1'b1;
        else hold_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic byt, input logic [31:0] addr,
                              input logic [15:0] wdata, input logic [15:0] din,
                              input int dly, input int hold, input int lat, input int asn,
                              input logic uds, input logic lds, input logic err,
                              input logic [15:0] rd, input logic [15:0] dout);
    vec_t v;
    v.wr = wr; v.byt = byt; v.addr = addr; v.wdata = wdata; v.din = din;
    v.dly = dly; v.hold = hold; v.lat = lat; v.asn = asn;
    v.uds = uds; v.lds = lds; v.err = err; v.rd = rd; v.dout = dout;
    return v;
  endfunction

  // Issue one command starting in the current cycle and follow it to Done.
  task automatic run_cmd(input vec_t v, input string nm);
    int          done_k = 0;
    int          as_n = 0, uds_n = 0, lds_n = 0, we_n = 0;
    int          exp_we;
    logic        addr_bad = 1'b0, dout_bad = 1'b0;
    logic        err_s  = 1'bx;
    logic        busy_s = 1'bx;
    logic [15:0] rd_s   = 'x;
    resp_delay = v.dly;
    resp_hold  = v.hold;
    CmdWrite = v.wr;
    CmdByte  = v.byt;
    CmdAddr  = v.addr;
    CmdData  = v.wdata;
    DataIn   = v.din;
    Start    = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        check({nm, "_busy"}, 32'(Busy), 32'd1);
        if (v.asn > 0) begin
          check({nm, "_addrph"}, Address, v.addr);
          check({nm, "_ctlph"}, 32'({AS_L, WE_L}), 32'({1'b1, ~v.wr}));
        end
      end
      // A Start while busy must be ignored.
      if (k == 2 && v.lat > 2) begin
        Start = 1'b1; CmdAddr = ~v.addr; CmdWrite = ~v.wr;
      end
      if (k == 3 && v.lat > 2) begin
        Start = 1'b0; CmdAddr = v.addr; CmdWrite = v.wr;
      end
      if (Done) begin
        done_k = k; err_s = Error; rd_s = RdData; busy_s = Busy;
        break;
      end
      if (!AS_L) begin
        as_n++;
        if (Address !== v.addr) addr_bad = 1'b1;
        if (v.wr && DataOut !== v.dout) dout_bad = 1'b1;
      end
      if (!UDS_L) uds_n++;
      if (!LDS_L) lds_n++;
      if (!WE_L)  we_n++;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    exp_we = (v.wr && v.asn > 0) ? v.asn + 1 : 0;
    check({nm, "_latency"}, 32'(done_k), 32'(v.lat));
    check({nm, "_error"}, 32'(err_s), 32'(v.err));
    check({nm, "_rddata"}, 32'(rd_s), 32'(v.rd));
    check({nm, "_busy_at_done"}, 32'(busy_s), 32'd0);
    check({nm, "_as_cycles"}, 32'(as_n), 32'(v.asn));
    check({nm, "_uds_cycles"}, 32'(uds_n), 32'(v.uds ? v.asn : 0));
    check({nm, "_lds_cycles"}, 32'(lds_n), 32'(v.lds ? v.asn : 0));
    check({nm, "_we_cycles"}, 32'(we_n), 32'(exp_we));
    check({nm, "_addr_stable"}, 32'(addr_bad), 32'd0);
    if (v.wr && v.asn > 0) check({nm, "_dout_stable"}, 32'(dout_bad), 32'd0);
  endtask

  initial begin
    int dn;
    vecs[0]  = mk(1'b1, 1'b0, 32'h00F0_0000, 16'hBEEF, 16'h0000, 2,  0, 6,  3, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
    vecs[1]  = mk(1'b0, 1'b1, 32'h0800_0003, 16'h0000, 16'h12A5, 0,  0, 4,  1, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'h0000);
    vecs[2]  = mk(1'b0, 1'b1, 32'h0800_0002, 16'h0000, 16'h12A5, 0,  0, 4,  1, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0000_0100, 16'h0000, 16'hCAFE, 1,  0, 5,  2, 1'b1, 1'b1, 1'b0, 16'hCAFE, 16'h0000);
    vecs[4]  = mk(1'b1, 1'b1, 32'h0000_0011, 16'h3C77, 16'h0000, 0,  0, 4,  1, 1'b0, 1'b1, 1'b0, 16'hCAFE, 16'h7777);
    vecs[5]  = mk(1'b1, 1'b1, 32'h0000_0010, 16'h0081, 16'h0000, 0,  0, 4,  1, 1'b1, 1'b0, 1'b0, 16'hCAFE, 16'h8181);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0000_2000, 16'h0000, 16'h9999, 99, 0, 11, 8, 1'b1, 1'b1, 1'b1, 16'hCAFE, 16'h0000);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0000_1001, 16'h1111, 16'h0000, 0,  0, 2,  0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 16'h0000);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0000_1003, 16'h0000, 16'h7777, 0,  0, 2,  0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 16'h0000);
    vecs[9]  = mk(1'b0, 1'b1, 32'h0000_1001, 16'h0000, 16'hFF5A, 3,  0, 7,  4, 1'b0, 1'b1, 1'b0, 16'h005A, 16'h0000);
    vecs[10] = mk(1'b0, 1'b0, 32'h0040_0000, 16'h0000, 16'h1234, 0,  3, 7,  1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_strobes", 32'({AS_L, UDS_L, LDS_L, WE_L}), 32'h0000_000F);
    check("rst_flags", 32'({Busy, Done, Error}), 32'd0);
    check("rst_rddata", 32'(RdData), 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_dataout", 32'(DataOut), 32'd0);
    Reset_H = 1'b0;
    @(posedge Clock); #1;

    // Table-driven commands, one idle clock between each
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i], $sformatf("v%0d", i));
      @(posedge Clock); #1;
      check($sformatf("v%0d_done_pulse", i), 32'({Done, Busy}), 32'd0);
    end

    // Back-to-back: Start issued in the Done cycle of a held-Dtack command
    run_cmd(vecs[10], "b2b_a");
    run_cmd(mk(1'b0, 1'b0, 32'h0050_0000, 16'h0000, 16'hA0A0, 0, 0, 4, 1,
               1'b1, 1'b1, 1'b0, 16'hA0A0, 16'h0000), "b2b_b");
    @(posedge Clock); #1;

    // Reset while in STROBE
    resp_delay = 99;
    resp_hold  = 0;
    CmdWrite = 1'b0; CmdByte = 1'b0; CmdAddr = 32'h0000_3000; DataIn = 16'h5A5A;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    check("rstmid_in_strobe", 32'(AS_L), 32'd0);
    Reset_H = 1'b1;
    @(posedge Clock); #1;
    check("rstmid_strobes", 32'({AS_L, UDS_L, LDS_L, WE_L}), 32'h0000_000F);
    check("rstmid_busy_done", 32'({Busy, Done}), 32'd0);
    check("rstmid_rddata", 32'(RdData), 32'd0);
    Reset_H = 1'b0;
    dn = 0;
    repeat (10) begin
      @(posedge Clock); #1;
      if (Done) dn++;
    end
    check("rstmid_no_done", 32'(dn), 32'd0);
    run_cmd(mk(1'b0, 1'b0, 32'h0000_3000, 16'h0000, 16'h5A5A, 0, 0, 4, 1,
               1'b1, 1'b1, 1'b0, 16'h5A5A, 16'h0000), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of clocks STROBE waits for Dtack_L before aborting (legal 1..65535).
REQ-002 Clock  input  1  single system clock; all state changes on the rising edge.
REQ-003 Reset_H  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  one-clock command request, accepted only when Busy=0.
REQ-005 CmdWrite  input  1  1=write cycle, 0=read cycle.
REQ-006 CmdByte  input  1  1=byte access, 0=word access.
REQ-007 CmdAddr  input  32  byte address of the access.
REQ-008 CmdData  input  16  write data; byte writes use bits 7-0.
REQ-009 Busy  output  1  high from the clock after Start is accepted until Done.
REQ-010 Done  output  1  one-clock completion pulse.
REQ-011 Error  output  1  valid with Done: 1=timeout or misaligned, 0=success.
REQ-012 RdData  output  16  read result, valid from Done until the next accepted Start.
REQ-013 Address  output  32  68000-style address bus to the DRAM controller/decoder.
REQ-014 DataOut  output  16  data bus to the responder.
REQ-015 DataIn  input  16  data bus from the responder.
REQ-016 AS_L, UDS_L, LDS_L, WE_L  output  1 each  active-low 68000 address strobe, upper/lower data strobes, write enable.
REQ-017 Dtack_L  input  1  active-low transfer acknowledge, synchronous to Clock.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, STROBE, TERM; all bus outputs SHALL be registered.
REQ-019 IDLE: AS_L=UDS_L=LDS_L=WE_L=1; when Start=1, latch command fields and go to ADDR; Start outside IDLE SHALL be ignored.
REQ-020 A word command with CmdAddr[0]=1 SHALL NOT start a bus cycle; the block SHALL assert Busy for one clock, then Done=1 with Error=1 and RdData unchanged.
REQ-021 ADDR (1 clock): Address=latched CmdAddr, WE_L=~CmdWrite, strobes still negated; DataOut driven with write data.
REQ-022 Write data: word access drives CmdData; byte access drives {CmdData[7:0],CmdData[7:0]}.
REQ-023 STROBE: AS_L=0; word access UDS_L=LDS_L=0; byte access UDS_L=0 only if CmdAddr[0]=0, else LDS_L=0 only; Address, WE_L, DataOut held stable.
REQ-024 STROBE timeout counter SHALL clear on entry and increment each clock Dtack_L=1.
REQ-025 When Dtack_L=0 is sampled in STROBE, the block SHALL latch RdData (reads only) and go to TERM.
REQ-026 Read latching: word -> DataIn; byte even -> {8'h00,DataIn[15:8]}; byte odd -> {8'h00,DataIn[7:0]}; writes leave RdData unchanged.
REQ-027 If the counter reaches TIMEOUT_CYCLES in STROBE with Dtack_L=1, go to TERM with an error flag set.
REQ-028 TERM: AS_L=UDS_L=LDS_L=1, WE_L=1; remain until Dtack_L=1 is sampled, then go to IDLE.
REQ-029 On the TERM->IDLE edge, Done SHALL pulse for exactly one clock with Error set per REQ-027, and Busy SHALL fall in the same clock.
REQ-030 Start asserted in the Done cycle SHALL be accepted; back-to-back commands need no idle gap.
REQ-031 Minimum read/write latency with Dtack_L already low: Start at clock N -> Done at N+4.

Reset
REQ-032 While Reset_H=1 at a rising edge: state=IDLE, AS_L=UDS_L=LDS_L=WE_L=1, Busy=0, Done=0, Error=0, RdData=0, Address=0, DataOut=0, counter=0.
REQ-033 Reset mid-cycle (any state) SHALL negate all strobes on that edge and SHALL NOT produce Done.

Verification
REQ-034 Word write 0x00F0_0000, data 0xBEEF, responder drives Dtack_L low 2 clocks after AS_L -> AS_L/UDS_L/LDS_L/WE_L low together, DataOut=0xBEEF stable, Done with Error=0.
REQ-035 Byte read 0x0800_0003, DataIn=0x12A5 -> only LDS_L asserted, RdData=0x00A5; repeat at 0x0800_0002 -> only UDS_L, RdData=0x0012.
REQ-036 Read with Dtack_L held high, TIMEOUT_CYCLES=8 -> strobes negate after 8 STROBE clocks, Done with Error=1.
REQ-037 Word command at 0x0000_1001 -> no AS_L assertion, Done+Error=1 two clocks after Start.
REQ-038 Reset_H pulsed while in STROBE -> strobes high next edge, no Done; subsequent Start completes normally.
REQ-039 Responder holds Dtack_L low 3 clocks after strobes negate -> Done delayed until Dtack_L high; Start in Done cycle starts next cycle with ADDR on the following clock.
